// File: rtl/cu_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, ALUOp codes, state encodings
// and the instruction-retire condition.
package cu_pkg;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ANDI = 4'h2;
    localparam logic [3:0] OP_ORI  = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_BNE  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h8;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_LOGIC = 2'b11;

    // FETCH must stay 0: the State port reads FETCH while outputs are forced low in reset
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_EXEC_I    = 4'd3;
    localparam logic [3:0] S_WB_ALU    = 4'd4;
    localparam logic [3:0] S_MEM_ADDR  = 4'd5;
    localparam logic [3:0] S_MEM_READ  = 4'd6;
    localparam logic [3:0] S_MEM_WRITE = 4'd7;
    localparam logic [3:0] S_WB_MEM    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;

    typedef enum logic [3:0] {
        ST_FETCH     = S_FETCH,
        ST_DECODE    = S_DECODE,
        ST_EXEC_R    = S_EXEC_R,
        ST_EXEC_I    = S_EXEC_I,
        ST_WB_ALU    = S_WB_ALU,
        ST_MEM_ADDR  = S_MEM_ADDR,
        ST_MEM_READ  = S_MEM_READ,
        ST_MEM_WRITE = S_MEM_WRITE,
        ST_WB_MEM    = S_WB_MEM,
        ST_BRANCH    = S_BRANCH,
        ST_JUMP      = S_JUMP
    } state_t;

    function automatic logic is_retire(state_t cur, state_t nxt, logic mem_ready);
        logic from_ok;
        from_ok = (cur == ST_WB_ALU) || (cur == ST_WB_MEM) || (cur == ST_BRANCH) ||
                  (cur == ST_JUMP) || ((cur == ST_MEM_WRITE) && mem_ready);
        return from_ok && (nxt == ST_FETCH);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Datapath <-> control-unit bundle: opcode/MemReady in, control strobes and debug out.
// RetiredCount exists only when CU_PERF_CNT_EN is defined.
interface multicycle_control_unit_if;
    logic [3:0]  opcode;
    logic        MemReady;
    logic        RegDst;
    logic        Jump;
    logic        Branch;
    logic        BranchNe;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        MemToReg;
    logic        ALUSrc;
    logic [1:0]  ALUOp;
    logic        PCWrite;
    logic        IRWrite;
    logic        IllegalOp;
    logic        BusError;
    logic [3:0]  State;
`ifdef CU_PERF_CNT_EN
    logic [15:0] RetiredCount;
`endif

    modport master (
        input  opcode, MemReady,
        output RegDst, Jump, Branch, BranchNe, MemRead, MemWrite, RegWrite, MemToReg,
               ALUSrc, ALUOp, PCWrite, IRWrite, IllegalOp, BusError, State
`ifdef CU_PERF_CNT_EN
        , output RetiredCount
`endif
    );

    modport slave (
        output opcode, MemReady,
        input  RegDst, Jump, Branch, BranchNe, MemRead, MemWrite, RegWrite, MemToReg,
               ALUSrc, ALUOp, PCWrite, IRWrite, IllegalOp, BusError, State
`ifdef CU_PERF_CNT_EN
        , input RetiredCount
`endif
    );
endinterface

// File: rtl/cu_mem_timer.sv
// Memory wait counter: clear on entry to a memory access, count while waiting,
// timeout flags the last allowed wait cycle (count == MEM_TIMEOUT-1).
module cu_mem_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == TW'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control unit; 2-5 cycles per instruction plus memory wait cycles,
// stalls on MemReady with timeout abort. Optional retire counter under CU_PERF_CNT_EN.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                        Clock,
    input  logic                        Reset,
    multicycle_control_unit_if.master   cu_if
);
    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       tmr_clr, tmr_en, tmr_timeout;
    logic       reg_dst, jump, branch, branch_ne, mem_read, mem_write, reg_write;
    logic       mem_to_reg, alu_src, pc_write, ir_write, illegal_op, bus_error;
    logic [1:0] alu_op;

    cu_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (Clock),
        .rst     (Reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .timeout (tmr_timeout)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        reg_dst    = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        illegal_op = 1'b0;
        bus_error  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                op_d = cu_if.opcode;
                case (cu_if.opcode)
                    OP_R:                    state_d = ST_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = ST_EXEC_I;
                    OP_LW, OP_SW:            state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:          state_d = ST_BRANCH;
                    OP_J:                    state_d = ST_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I, ST_WB_ALU: begin
                // WB_ALU keeps the EXEC operand/ALU selects stable through write-back
                if (op_q == OP_R) begin
                    reg_dst = 1'b1;
                    alu_op  = ALU_RTYPE;
                end else begin
                    alu_src = 1'b1;
                    alu_op  = (op_q == OP_ADDI) ? ALU_ADD : ALU_LOGIC;
                end
                reg_write = (state_q == ST_WB_ALU);
                state_d   = (state_q == ST_WB_ALU) ? ST_FETCH : ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                alu_src = 1'b1;
                tmr_clr = 1'b1;
                state_d = (op_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ, ST_MEM_WRITE: begin
                alu_src   = 1'b1;
                mem_read  = (state_q == ST_MEM_READ);
                mem_write = (state_q == ST_MEM_WRITE);
                if (cu_if.MemReady) begin
                    state_d = (state_q == ST_MEM_READ) ? ST_WB_MEM : ST_FETCH;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_timeout) begin
                        bus_error = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_op    = ALU_SUB;
                branch    = (op_q == OP_BEQ);
                branch_ne = (op_q == OP_BNE);
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                jump    = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Every output is forced low during reset, which also drops an in-flight MemWrite
    always_comb begin
        cu_if.RegDst    = reg_dst    & ~Reset;
        cu_if.Jump      = jump       & ~Reset;
        cu_if.Branch    = branch     & ~Reset;
        cu_if.BranchNe  = branch_ne  & ~Reset;
        cu_if.MemRead   = mem_read   & ~Reset;
        cu_if.MemWrite  = mem_write  & ~Reset;
        cu_if.RegWrite  = reg_write  & ~Reset;
        cu_if.MemToReg  = mem_to_reg & ~Reset;
        cu_if.ALUSrc    = alu_src    & ~Reset;
        cu_if.ALUOp     = Reset ? 2'b00 : alu_op;
        cu_if.PCWrite   = pc_write   & ~Reset;
        cu_if.IRWrite   = ir_write   & ~Reset;
        cu_if.IllegalOp = illegal_op & ~Reset;
        cu_if.BusError  = bus_error  & ~Reset;
        cu_if.State     = Reset ? S_FETCH : state_q;
    end

`ifdef CU_PERF_CNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (is_retire(state_q, state_d, cu_if.MemReady)) begin
            retired_d = retired_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign cu_if.RetiredCount = Reset ? 16'd0 : retired_q;
`endif

endmodule
